// File: rtl/mux_arb_rr2_pkg.sv
// Shared types and constants for the two-lane round-robin lane-mux scheduler.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SERVE0 = 2'b01,
    SERVE1 = 2'b10
  } state_e;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  localparam int unsigned BURST_MAX_DEF = 4;

endpackage

// File: rtl/mux_arb_rr2_out_stage.sv
// Two-stage output pipe: stage 1 latches the popped lane as the mux select,
// stage 2 latches the selected FIFO word, zeroed whenever it is not valid.
module mux_arb_out_stage
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pop_vld_i,
  input  logic                  pop_lane_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  output logic                  selector_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  sel_q, sel_d;
  logic                  vld1_q;
  logic                  vout_q;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    sel_d  = pop_vld_i ? pop_lane_i : sel_q;
    dout_d = '0;
    if (vld1_q) begin
      dout_d = sel_q ? data1_i : data0_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q  <= LANE0;
      vld1_q <= 1'b0;
      vout_q <= 1'b0;
      dout_q <= '0;
    end else begin
      sel_q  <= sel_d;
      vld1_q <= pop_vld_i;
      vout_q <= vld1_q;
      dout_q <= dout_d;
    end
  end

  assign selector_o = sel_q;
  assign valid_o    = vout_q;
  assign data_o     = dout_q;

endmodule

// File: rtl/mux_arb_rr2.sv
// Two-lane round-robin pop scheduler driving the 2:1 lane mux select.
// Define MUX_ARB_BURST_EN for bursts of up to BURST_MAX pops; otherwise strict alternation.
module mux_arb_rr2
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned BURST_MAX  = BURST_MAX_DEF,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty0,
  input  logic                  empty1,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic                  pause,
  output logic                  pop0,
  output logic                  pop1,
  output logic                  selector,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  if (BURST_MAX < 1 || BURST_MAX > 7 || BURST_MAX >= (1 << CNT_W)) begin : g_cfg_check
    $error("mux_arb_rr2: BURST_MAX must be 1..7 and fit in CNT_W bits");
  end

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   keep0, keep1;

`ifdef MUX_ARB_BURST_EN
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign keep0 = !empty0 && ((cnt_q < BURST_LIM) || empty1);
  assign keep1 = !empty1 && ((cnt_q < BURST_LIM) || empty0);

  // Burst count follows the state transition: cleared in IDLE, restarted on
  // entering a lane, advanced (saturating) on each further pop of that lane.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == IDLE) begin
      cnt_d = '0;
    end else if (state_d != state_q) begin
      cnt_d = CNT_W'(1);
    end else if ((pop0 || pop1) && (cnt_q < BURST_LIM)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign keep0 = !empty0 && empty1;
  assign keep1 = !empty1 && empty0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    pop0    = 1'b0;
    pop1    = 1'b0;
    if (!pause && !reset) begin
      unique case (state_q)
        IDLE: begin
          if (!empty0 && (empty1 || last_q == LANE1)) begin
            pop0    = 1'b1;
            state_d = SERVE0;
          end else if (!empty1) begin
            pop1    = 1'b1;
            state_d = SERVE1;
          end
        end
        SERVE0: begin
          if (keep0) begin
            pop0 = 1'b1;
          end else if (!empty1) begin
            pop1    = 1'b1;
            state_d = SERVE1;
            last_d  = LANE0;
          end else begin
            state_d = IDLE;
            last_d  = LANE0;
          end
        end
        SERVE1: begin
          if (keep1) begin
            pop1 = 1'b1;
          end else if (!empty0) begin
            pop0    = 1'b1;
            state_d = SERVE0;
            last_d  = LANE1;
          end else begin
            state_d = IDLE;
            last_d  = LANE1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LANE1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  mux_arb_out_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_stage (
    .clk       (clk),
    .reset     (reset),
    .pop_vld_i (pop0 | pop1),
    .pop_lane_i(pop1),
    .data0_i   (data0),
    .data1_i   (data1),
    .selector_o(selector),
    .valid_o   (valid_out),
    .data_o    (data_out)
  );

endmodule

// File: tb/tb_mux_arb_rr2.sv
// Self-checking bench for mux_arb_rr2: IDLE decision table, directed corner
// sequences and randomized traffic against a word-level reference model.
module tb_mux_arb_rr2;

`ifdef MUX_ARB_BURST_EN
  localparam int EFF_BURST = 4;
`else
  localparam int EFF_BURST = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       empty0, empty1;
  logic [3:0] data0, data1;
  logic       pause;
  logic       pop0, pop1;
  logic       selector;
  logic       valid_out;
  logic [3:0] data_out;

  mux_arb_rr2 #(
    .DATA_WIDTH(4),
    .BURST_MAX (4),
    .CNT_W     (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .empty0   (empty0),
    .empty1   (empty1),
    .data0    (data0),
    .data1    (data1),
    .pause    (pause),
    .pop0     (pop0),
    .pop1     (pop1),
    .selector (selector),
    .valid_out(valid_out),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Lane FIFO contents and reference-model state
  int q0[$], q1[$];
  int stream[$];
  int cyc, first_v, last_v, first_p;
  int m_cur, m_run, m_last;
  int m_sel, m_v1, m_w1, m_vout, m_dout;

  typedef struct {
    logic pause;
    logic e0;
    logic e1;
    logic p0;
    logic p1;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic sync_flags();
    empty0 = (q0.size() == 0);
    empty1 = (q1.size() == 0);
  endtask

  task automatic model_reset();
    m_cur = -1; m_run = 0; m_last = 1;
    m_sel = 0; m_v1 = 0; m_w1 = 0; m_vout = 0; m_dout = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic clear_stream();
    stream.delete();
    first_v = -1; last_v = -1; first_p = -1;
  endtask

  // Which lane the scheduler should pop right now (-1 = none)
  function automatic int model_pick();
    bit ne0, ne1, nek, neo;
    int k;
    if (pause || reset) return -1;
    ne0 = !empty0; ne1 = !empty1;
    if (m_cur < 0) begin
      if (ne0 && ne1) return (m_last == 0) ? 1 : 0;
      if (ne0) return 0;
      if (ne1) return 1;
      return -1;
    end
    k   = m_cur;
    nek = (k == 0) ? ne0 : ne1;
    neo = (k == 0) ? ne1 : ne0;
    if (nek && (m_run < EFF_BURST || !neo)) return k;
    if (neo) return 1 - k;
    return -1;
  endfunction

  task automatic model_fsm(input int pick);
    if (pause) return;
    if (pick < 0) begin
      if (m_cur >= 0) begin
        m_last = m_cur; m_cur = -1; m_run = 0;
      end
    end else if (pick == m_cur) begin
      if (m_run < EFF_BURST) m_run++;
    end else begin
      if (m_cur >= 0) m_last = m_cur;
      m_cur = pick; m_run = 1;
    end
  endtask

  // One clock: check at negedge, advance model/FIFOs just after posedge.
  task automatic step();
    int pick;
    @(negedge clk);
    pick = model_pick();
    chk("pop0", 16'(pop0), 16'(pick == 0));
    chk("pop1", 16'(pop1), 16'(pick == 1));
    chk("selector", 16'(selector), 16'(m_sel));
    chk("valid_out", 16'(valid_out), 16'(m_vout));
    chk("data_out", 16'(data_out), 16'(m_dout));
    if (pick >= 0 && first_p < 0) first_p = cyc;
    if (valid_out === 1'b1) begin
      stream.push_back(int'(data_out));
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    @(posedge clk);
    m_dout = m_v1 ? m_w1 : 0;
    m_vout = m_v1;
    m_v1   = (pick >= 0) ? 1 : 0;
    if (pick >= 0) begin
      m_sel = pick;
      m_w1  = (pick == 0) ? q0[0] : q1[0];
    end
    model_fsm(pick);
    #1;
    if (pick == 0) data0 = 4'(q0.pop_front());
    if (pick == 1) data1 = 4'(q1.pop_front());
    sync_flags();
    cyc++;
  endtask

  task automatic chk_stream(input string name, input int exp[$], input bit gapless);
    chk({name, "_len"}, 16'(stream.size()), 16'(exp.size()));
    for (int i = 0; i < exp.size() && i < stream.size(); i++)
      chk({name, "_word"}, 16'(stream[i]), 16'(exp[i]));
    if (gapless) chk({name, "_gapfree"}, 16'(last_v - first_v + 1), 16'(exp.size()));
  endtask

  initial begin
    int exp_q[$];
    reset = 1'b1; pause = 1'b0; empty0 = 1'b1; empty1 = 1'b1;
    data0 = '0; data1 = '0; cyc = 0;
    model_reset(); clear_stream();

    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    #2;
    chk("rst_selector", 16'(selector), 16'd0);
    chk("rst_valid", 16'(valid_out), 16'd0);
    chk("rst_data", 16'(data_out), 16'd0);
    chk("rst_pops", 16'({pop0, pop1}), 16'd0);

    // IDLE decisions straight out of reset
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      reset = 1'b1;
      #1;
      reset  = 1'b0;
      pause  = tbl[i].pause;
      empty0 = tbl[i].e0;
      empty1 = tbl[i].e1;
      #1;
      chk("tbl_pop0", 16'(pop0), 16'(tbl[i].p0));
      chk("tbl_pop1", 16'(pop1), 16'(tbl[i].p1));
      empty0 = 1'b1; empty1 = 1'b1; pause = 1'b0;
    end
    @(posedge clk); #1;

    // Both lanes empty for 10 cycles
    do_reset(); clear_stream();
    repeat (10) step();
    chk("idle_no_output", 16'(stream.size()), 16'd0);

    // Lane 0 only: 3, 5, 7
    do_reset(); clear_stream();
    q0 = '{3, 5, 7}; sync_flags();
    repeat (8) step();
    exp_q = '{3, 5, 7};
    chk_stream("lane0_only", exp_q, 1'b1);
    chk("lane0_latency", 16'(first_v - first_p), 16'd2);

    // Both lanes with six words each
    do_reset(); clear_stream();
    q0 = '{1, 2, 3, 4, 5, 6}; q1 = '{9, 10, 11, 12, 13, 14}; sync_flags();
    repeat (16) step();
`ifdef MUX_ARB_BURST_EN
    exp_q = '{1, 2, 3, 4, 9, 10, 11, 12, 5, 6, 13, 14};
`else
    exp_q = '{1, 9, 2, 10, 3, 11, 4, 12, 5, 13, 6, 14};
`endif
    chk_stream("both_lanes", exp_q, 1'b1);

    // Pause for 3 cycles after two pops of a lane-0 burst
    do_reset(); clear_stream();
    q0 = '{2, 3, 4, 5, 6, 7}; q1 = '{10, 11, 12, 13}; sync_flags();
    repeat (2) step();
    pause = 1'b1;
    repeat (3) step();
    pause = 1'b0;
    repeat (14) step();
`ifdef MUX_ARB_BURST_EN
    exp_q = '{2, 3, 4, 5, 10, 11, 12, 13, 6, 7};
`else
    exp_q = '{2, 10, 3, 11, 4, 12, 5, 13, 6, 7};
`endif
    chk_stream("pause_burst", exp_q, 1'b0);

    // Lane 1 empties in the cycle it would otherwise be served again
    do_reset(); clear_stream();
    q1 = '{8, 9, 10}; sync_flags();
    step();
    q1.delete(); q0 = '{3, 4}; sync_flags();
    #1;
    chk("late_empty_pop1", 16'(pop1), 16'd0);
    chk("late_empty_pop0", 16'(pop0), 16'd1);
    repeat (6) step();

    // Asynchronous reset pulse while serving lane 1 with words in flight
    do_reset(); clear_stream();
    q1 = '{10, 11, 12, 13, 14, 15}; sync_flags();
    repeat (3) step();
    q0 = '{1, 2}; sync_flags();
    #1;
    reset = 1'b1;
    #1;
    chk("arst_valid", 16'(valid_out), 16'd0);
    chk("arst_data", 16'(data_out), 16'd0);
    chk("arst_selector", 16'(selector), 16'd0);
    chk("arst_pops", 16'({pop0, pop1}), 16'd0);
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst_first_pop0", 16'(pop0), 16'd1);
    chk("arst_first_pop1", 16'(pop1), 16'd0);
    repeat (8) step();

    // Randomized traffic and back-pressure
    q0.delete(); q1.delete();
    do_reset(); clear_stream();
    for (int i = 0; i < 400; i++) begin
      if (q0.size() < 8 && $urandom_range(0, 2) != 0) q0.push_back(int'($urandom_range(0, 15)));
      if (q1.size() < 8 && $urandom_range(0, 2) != 0) q1.push_back(int'($urandom_range(0, 15)));
      pause = ($urandom_range(0, 4) == 0);
      sync_flags();
      step();
    end
    pause = 1'b0;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
